// File: rtl/selector8_arb.sv
// Round-robin two-source arbiter driving the selector8 SEL input; grant is registered, valid one edge after request.
// An owner holds the path at most HOLD_MAX cycles while the other source waits; no idle bubble on a handover.
module selector8_arb #(
   parameter int HOLD_MAX = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_A,
   input  logic       REQ_B,
   output logic       GNT_A,
   output logic       GNT_B,
   output logic       SEL,
   output logic       BUSY,
   output logic [3:0] HOLD_CNT
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

   state_t     state;
   state_t     state_nxt;
   logic       last_b;
   logic       last_b_nxt;
   logic       sel_nxt;
   logic [3:0] hold_nxt;

   always_comb begin
      state_nxt  = state;
      hold_nxt   = HOLD_CNT;
      sel_nxt    = SEL;
      last_b_nxt = last_b;

      case (state)
         IDLE: begin
            // tie goes to whichever source was not served last
            if (REQ_A && (!REQ_B || last_b))
               state_nxt = OWN_A;
            else if (REQ_B)
               state_nxt = OWN_B;
         end
         OWN_A: begin
            if (!REQ_A)
               state_nxt = REQ_B ? OWN_B : IDLE;
            else if (REQ_B && HOLD_CNT == HOLD_LAST)
               state_nxt = OWN_B;
            else if (HOLD_CNT != HOLD_LAST)
               hold_nxt = HOLD_CNT + 4'd1;
         end
         OWN_B: begin
            if (!REQ_B)
               state_nxt = REQ_A ? OWN_A : IDLE;
            else if (REQ_A && HOLD_CNT == HOLD_LAST)
               state_nxt = OWN_A;
            else if (HOLD_CNT != HOLD_LAST)
               hold_nxt = HOLD_CNT + 4'd1;
         end
         default: state_nxt = IDLE;
      endcase

      // entry actions; SEL is left alone when going idle
      if (state_nxt == IDLE) begin
         hold_nxt = 4'd0;
      end else if (state_nxt == OWN_A && state != OWN_A) begin
         hold_nxt   = 4'd0;
         sel_nxt    = 1'b0;
         last_b_nxt = 1'b0;
      end else if (state_nxt == OWN_B && state != OWN_B) begin
         hold_nxt   = 4'd0;
         sel_nxt    = 1'b1;
         last_b_nxt = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         GNT_A    <= 1'b0;
         GNT_B    <= 1'b0;
         SEL      <= 1'b0;
         BUSY     <= 1'b0;
         HOLD_CNT <= 4'd0;
      end else begin
         state    <= state_nxt;
         last_b   <= last_b_nxt;
         GNT_A    <= (state_nxt == OWN_A);
         GNT_B    <= (state_nxt == OWN_B);
         SEL      <= sel_nxt;
         BUSY     <= (state_nxt != IDLE);
         HOLD_CNT <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_selector8_arb.sv
// Bench for selector8_arb: HOLD_MAX=4 instance for arbitration scenarios, HOLD_MAX=1 instance feeding a selector8 model.
module tb_selector8_arb;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       REQ_A = 1'b0;
   logic       REQ_B = 1'b0;
   logic       GNT_A, GNT_B, SEL, BUSY;
   logic [3:0] HOLD_CNT;

   logic       req1_a = 1'b0;
   logic       req1_b = 1'b0;
   logic       gnt1_a, gnt1_b, sel1, busy1;
   logic [3:0] hold1;

   logic [7:0] src_a = 8'hAA;
   logic [7:0] src_b = 8'h55;
   logic [7:0] y;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sb[$];
   logic [9:0] sb1[$];

   always #5 CLK = ~CLK;

   selector8_arb #(.HOLD_MAX(4)) dut (
      .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
      .GNT_A(GNT_A), .GNT_B(GNT_B), .SEL(SEL), .BUSY(BUSY), .HOLD_CNT(HOLD_CNT)
   );

   selector8_arb #(.HOLD_MAX(1)) dut1 (
      .CLK(CLK), .RST(RST), .REQ_A(req1_a), .REQ_B(req1_b),
      .GNT_A(gnt1_a), .GNT_B(gnt1_b), .SEL(sel1), .BUSY(busy1), .HOLD_CNT(hold1)
   );

   // downstream selector8
   assign y = sel1 ? src_b : src_a;

   function automatic logic [7:0] ev(input logic ga, input logic gb, input logic s, input logic [3:0] h);
      return {ga, gb, s, ga | gb, h};
   endfunction

   // apply inputs mid-cycle, then land 1 time unit after the next rising edge
   task automatic drive(input logic rst, input logic ra, input logic rb);
      @(negedge CLK);
      RST   = rst;
      REQ_A = ra;
      REQ_B = rb;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] obs, exp;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) sb.push_back(ev(0, 0, 0, 4'd0));
         else       sb.push_back(ev(1, 0, 0, 4'd0));
         drive(i < 2, 1'b1, 1'b1);
         obs = {GNT_A, GNT_B, SEL, BUSY, HOLD_CNT};
         exp = sb.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset step %0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] obs, exp;
      sb.push_back(ev(0, 0, 0, 4'd0));
      drive(1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 12; i++) begin
         logic ob;
         ob = ((i / 4) % 2) == 1;
         sb.push_back(ev(!ob, ob, ob, 4'(i % 4)));
         drive(1'b0, 1'b1, 1'b1);
         obs = {GNT_A, GNT_B, SEL, BUSY, HOLD_CNT};
         exp = sb.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL round_robin cycle %0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] obs, exp;
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         if (i < 10) sb.push_back(ev(1, 0, 0, (i < 3) ? 4'(i) : 4'd3));
         else        sb.push_back(ev(0, 1, 1, 4'd0));
         drive(1'b0, 1'b1, i == 10);
         obs = {GNT_A, GNT_B, SEL, BUSY, HOLD_CNT};
         exp = sb.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL saturation cycle %0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_early_release();
      logic [7:0] obs, exp;
      logic       ra[9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
      logic       rb[9] = '{1, 1, 0, 0, 0, 1, 0, 1, 0};
      logic [7:0] ex[9];
      ex[0] = ev(0, 1, 1, 4'd0);
      ex[1] = ev(0, 1, 1, 4'd1);
      ex[2] = ev(1, 0, 0, 4'd0);   // direct handover, BUSY stays 1
      ex[3] = ev(0, 0, 0, 4'd0);
      ex[4] = ev(0, 0, 0, 4'd0);
      ex[5] = ev(0, 1, 1, 4'd0);
      ex[6] = ev(0, 0, 1, 4'd0);   // SEL holds 1 in IDLE
      ex[7] = ev(1, 0, 0, 4'd0);   // B served last, A wins the tie
      ex[8] = ev(0, 0, 0, 4'd0);
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         sb.push_back(ex[i]);
         drive(1'b0, ra[i], rb[i]);
         obs = {GNT_A, GNT_B, SEL, BUSY, HOLD_CNT};
         exp = sb.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL early_release step %0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [7:0] obs, exp;
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i < 3)       sb.push_back(ev(0, 1, 1, 4'(i)));
         else if (i == 3) sb.push_back(ev(0, 0, 0, 4'd0));
         else             sb.push_back(ev(1, 0, 0, 4'(i - 4)));
         drive(i == 3, i >= 4, 1'b1);
         obs = {GNT_A, GNT_B, SEL, BUSY, HOLD_CNT};
         exp = sb.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid step %0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back_hold1();
      logic [9:0] obs, exp;
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) sb1.push_back({2'b10, 8'hAA});
         else            sb1.push_back({2'b01, 8'h55});
         @(negedge CLK);
         RST    = 1'b0;
         req1_a = 1'b1;
         req1_b = 1'b1;
         @(posedge CLK);
         #1;
         obs = {gnt1_a, gnt1_b, y};
         exp = sb1.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL hold1_e2e cycle %0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_saturation();
      test_early_release();
      test_reset_mid_grant();
      test_back_to_back_hold1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/selector8_arb.md
Name: selector8_arb

Overview:
- Sequential arbiter directly upstream of the 8-bit 2:1 selector (selector8).
- Two sources, A and B, request the shared 8-bit output path. The block grants one source at a time and drives the selector's SEL input.
- Uses round-robin fairness and a bounded hold time so that neither source can starve the other.
- SEL=0 routes A to Y; SEL=1 routes B to Y.

Parameters:
- HOLD_MAX, default 4: maximum consecutive cycles a granted source keeps the path while the other source is waiting. Legal range is 1..15.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_A  input  1  source A requests the path (level, held while data is wanted).
- REQ_B  input  1  source B requests the path.
- GNT_A  output  1  A owns the path this cycle.
- GNT_B  output  1  B owns the path this cycle.
- SEL  output  1  select to selector8: 0 = A, 1 = B.
- BUSY  output  1  GNT_A | GNT_B.
- HOLD_CNT  output  4  cycles the current owner has held the grant, minus 1; 0 in IDLE.

Interface (already decided):
- One clock, CLK; reset RST is synchronous and active-high.
- All outputs are registered; no combinational path from REQ_x to any output.

Behaviour:
- Reset (RST=1 at a rising edge, including in the middle of a grant):
  - state=IDLE, GNT_A=0, GNT_B=0, BUSY=0, SEL=0, HOLD_CNT=0.
  - last_served=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B.
  - GNT_A=1 only in OWN_A; GNT_B=1 only in OWN_B.
  - GNT_A and GNT_B are never 1 together.
- Latency: a request sampled at edge n is granted from edge n (outputs valid after edge n), i.e. 1 cycle after the request is presented.
- IDLE:
  - REQ_A only -> OWN_A.
  - REQ_B only -> OWN_B.
  - Both -> the source that is not last_served.
  - Neither -> stay in IDLE; SEL holds its last value (no toggle in IDLE).
- On entering OWN_X:
  - HOLD_CNT=0.
  - SEL=0 for A, 1 for B.
  - last_served<=X.
- OWN_X, REQ_X=0:
  - Other source requesting -> switch directly to OWN_other, with no idle bubble.
  - Otherwise -> IDLE; HOLD_CNT<=0.
- OWN_X, REQ_X=1, other requesting:
  - HOLD_CNT < HOLD_MAX-1 -> HOLD_CNT+1.
  - HOLD_CNT = HOLD_MAX-1 -> switch to OWN_other.
- OWN_X, REQ_X=1, other idle:
  - Stay in OWN_X.
  - HOLD_CNT increments, saturating at HOLD_MAX-1 (no wrap).
  - If the other source requests later while HOLD_CNT is saturated, the switch occurs at the next edge.
- HOLD_MAX=1: the grant alternates every cycle while both sources request.
- Simultaneous events:
  - The owner drops its request on the same edge the other raises its request -> direct switch.
  - Both sources drop -> IDLE.
- Switch edge: GNT_A and GNT_B change on the same edge; SEL changes on that same edge.

Test Plan:
- Reset/idle: RST=1 for 2 cycles with REQ_A=REQ_B=1 -> all outputs 0; release RST -> after 1 edge GNT_A=1, SEL=0, HOLD_CNT=0.
- Round-robin with HOLD_MAX=4: REQ_A=REQ_B=1 held for 12 cycles -> grant sequence A,A,A,A,B,B,B,B,A,A,A,A. SEL follows 0/1 in the same pattern; GNT_A&GNT_B is never 1.
- Single requester saturation: REQ_A=1 alone for 10 cycles -> GNT_A stays 1 and HOLD_CNT goes 0,1,2,3,3,3… Then raise REQ_B -> GNT_B=1 and SEL=1 on the next edge.
- Early release: in OWN_B with HOLD_CNT=1, drop REQ_B while REQ_A=1 -> next edge GNT_A=1, SEL=0, HOLD_CNT=0, with no BUSY=0 cycle. Then drop REQ_A -> IDLE, BUSY=0, SEL remains 0.
- Reset mid-grant: OWN_B with HOLD_CNT=2, assert RST one cycle -> next edge GNT_B=0, SEL=0, HOLD_CNT=0. After release with both requesting -> A granted first.
- End-to-end with selector8: A=8'hAA, B=8'h55, both requesting, HOLD_MAX=1 -> Y alternates 8'hAA, 8'h55 every cycle, matching SEL.
